// File: rtl/input_sequencer.sv
// Operator front end for picoMIPS: debounces sw8, captures X1/Y1 from sws,
// launches the cpu and holds its result for the number display.
module input_sequencer #(
  parameter int n          = 8,
  parameter int DEB_CYCLES = 250000,
  parameter int TIMEOUT    = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sw8,
  input  logic [n-1:0] sws,
  input  logic         cpu_done,
  input  logic [n-1:0] cpu_result,
  output logic [n-1:0] x_out,
  output logic [n-1:0] y_out,
  output logic         start,
  output logic [n-1:0] display,
  output logic [1:0]   phase,
  output logic         err
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] WAIT_X = 2'd0;
  localparam logic [1:0] WAIT_Y = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;
  localparam logic [1:0] SHOW   = 2'd3;

  logic [1:0]    sync_pipe;
  logic          sw8_db, sw8_db_q;
  logic [DW-1:0] deb_cnt;
  logic [TW-1:0] run_cnt;
  logic [1:0]    state;
  logic          press;

  wire sw8_s = sync_pipe[1];

  assign press = sw8_db & ~sw8_db_q;
  assign phase = state;

  // Debouncer: the synchronised level must disagree with the accepted level
  // for DEB_CYCLES consecutive cycles before it is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_pipe <= '0;
      sw8_db    <= 1'b0;
      sw8_db_q  <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      sync_pipe <= {sync_pipe[0], sw8};
      sw8_db_q  <= sw8_db;
      if (sw8_s == sw8_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
        sw8_db  <= sw8_s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= WAIT_X;
      x_out   <= '0;
      y_out   <= '0;
      start   <= 1'b0;
      display <= '0;
      err     <= 1'b0;
      run_cnt <= '0;
    end else begin
      start <= 1'b0;
      case (state)
        WAIT_X: if (press) begin
          x_out <= sws;
          err   <= 1'b0;
          state <= WAIT_Y;
        end
        WAIT_Y: if (press) begin
          y_out   <= sws;
          start   <= 1'b1;
          run_cnt <= '0;
          state   <= RUN;
        end
        // cpu_done is checked first so it wins over a coincident timeout
        RUN: begin
          if (cpu_done) begin
            display <= cpu_result;
            state   <= SHOW;
          end else if (run_cnt == TW'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= SHOW;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        default: if (press) state <= WAIT_X;
      endcase
    end
  end

endmodule

// File: tb/tb_input_sequencer.sv
// Scoreboard bench for input_sequencer: transaction-level model pushes expected
// phase snapshots and start times; a negedge monitor pops and compares.
module tb_input_sequencer;
  localparam int N   = 8;
  localparam int DEB = 4;
  localparam int TO  = 16;

  logic         clk = 1'b0, reset = 1'b1, sw8 = 1'b0, cpu_done = 1'b0;
  logic [N-1:0] sws = '0, cpu_result = '0;
  logic [N-1:0] x_out, y_out, display;
  logic         start, err;
  logic [1:0]   phase;

  input_sequencer #(.n(N), .DEB_CYCLES(DEB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .sw8(sw8), .sws(sws), .cpu_done(cpu_done),
    .cpu_result(cpu_result), .x_out(x_out), .y_out(y_out), .start(start),
    .display(display), .phase(phase), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]   ph;
    logic [N-1:0] x, y, d;
    logic         e;
  } snap_t;

  snap_t exp_q[$];
  int    start_q[$];
  int    n_chk = 0, n_fail = 0;
  bit    mon_en = 0;

  // operator-visible model state
  logic [N-1:0] m_x = '0, m_y = '0, m_d = '0;
  logic         m_e = 1'b0;

  function automatic snap_t mk(input logic [1:0] ph);
    snap_t s;
    s.ph = ph; s.x = m_x; s.y = m_y; s.d = m_d; s.e = m_e;
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_phase"}, 32'(phase), 0);
    chk({tag, "_x"}, 32'(x_out), 0);
    chk({tag, "_y"}, 32'(y_out), 0);
    chk({tag, "_display"}, 32'(display), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_start"}, 32'(start), 0);
  endtask

  // Monitor: every phase change must match the next expected snapshot,
  // every start pulse the next expected cycle, and start is one cycle wide.
  initial begin
    logic [1:0] prev_ph;
    logic       prev_start;
    snap_t      s;
    prev_ph = 2'd0; prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (start) begin
          if (prev_start) chk("start_width", 2, 1);
          else if (start_q.size() == 0) chk("unexpected_start", 1, 0);
          else chk("start_cycle", cyc, start_q.pop_front());
        end
        if (phase !== prev_ph) begin
          if (exp_q.size() == 0) chk("unexpected_phase", 32'(phase), 32'(prev_ph));
          else begin
            s = exp_q.pop_front();
            chk("phase", 32'(phase), 32'(s.ph));
            chk("x_out", 32'(x_out), 32'(s.x));
            chk("y_out", 32'(y_out), 32'(s.y));
            chk("display", 32'(display), 32'(s.d));
            chk("err", 32'(err), 32'(s.e));
          end
        end
      end
      prev_ph = phase;
      prev_start = start;
    end
  end

  // One sw8 press (optionally preceded by 1-0-1-0 bounce of 2-cycle pulses),
  // release, and a stray cpu_done pulse early on that must be ignored.
  task automatic press(input logic [N-1:0] v, input bit bounce);
    int len;
    len = bounce ? 8 : 0;
    sws = v;
    for (int i = 0; i < len + 18; i++) begin
      @(negedge clk);
      sw8 = (i < len) ? ((i % 4) < 2) : (i < len + 10);
      cpu_done = (i == 2);
      cpu_result = N'($urandom);
    end
  endtask

  task automatic glitch();
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      sw8 = (i < DEB - 1);
    end
  endtask

  task automatic x_press(input logic [N-1:0] v, input bit bounce);
    m_x = v; m_e = 1'b0;
    exp_q.push_back(mk(2'd1));
    press(v, bounce);
  endtask

  task automatic show_press();
    exp_q.push_back(mk(2'd0));
    press(N'($urandom), $urandom_range(0, 1));
  endtask

  // Y press plus RUN phase. k = RUN cycle index (0 = start cycle) carrying
  // cpu_done; rp = second press inside RUN; rst_at >= 0 pulses reset there.
  task automatic run_seq(input logic [N-1:0] y, input int k, input logic [N-1:0] res,
                         input bit rp, input int rst_at);
    m_y = y;
    exp_q.push_back(mk(2'd2));
    if (rst_at >= 0) begin
      m_x = '0; m_y = '0; m_d = '0; m_e = 1'b0;
      exp_q.push_back(mk(2'd0));
    end else begin
      if (k < TO) m_d = res;
      else m_e = 1'b1;
      exp_q.push_back(mk(2'd3));
    end
    sws = y;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (i == 0) start_q.push_back(cyc + DEB + 3);
      if (rp) sw8 = (i < 9) || (i >= 15 && i < 25);
      else    sw8 = (i < ((rst_at >= 0) ? 8 : 10));
      if (rp && i >= 15) sws = ~y;
      cpu_done = (i == DEB + 3 + k);
      cpu_result = res;
      reset = (i == rst_at);
      if (rst_at >= 0 && i == rst_at + 1) check_zero("rst_run");
    end
  endtask

  initial begin
    int k;
    bit rp;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_zero("por");
    mon_en = 1;

    // directed: basic operand cycle and result display
    x_press(8'h12, 0);
    run_seq(8'h34, 3, 8'hA5, 0, -1);
    show_press();

    // glitch alone, then bounced press; timeout with a press inside RUN
    glitch();
    x_press(8'h56, 1);
    run_seq(8'h78, TO, 8'h3C, 1, -1);
    show_press();

    // cpu_done on the start cycle, on the last RUN cycle, and just too late
    x_press(8'h9A, 0);
    run_seq(8'hBC, 0, 8'h11, 0, -1);
    show_press();
    x_press(8'hDE, 0);
    run_seq(8'hF0, TO - 1, 8'h22, 0, -1);
    show_press();
    x_press(8'h01, 0);
    run_seq(8'h02, TO, 8'h33, 0, -1);
    show_press();

    // reset in WAIT_Y, then reset in RUN
    x_press(8'h44, 0);
    m_x = '0; m_y = '0; m_d = '0; m_e = 1'b0;
    exp_q.push_back(mk(2'd0));
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check_zero("rst_wy");
    x_press(8'h55, 0);
    run_seq(8'h66, TO + 3, 8'h77, 0, 9);

    // randomized transactions
    for (int t = 0; t < 10; t++) begin
      if ($urandom_range(0, 2) == 0) glitch();
      x_press(N'($urandom), $urandom_range(0, 1));
      k = $urandom_range(0, TO + 3);
      rp = (k >= TO) && ($urandom_range(0, 1) == 1);
      run_seq(N'($urandom), k, N'($urandom), rp, -1);
      show_press();
    end

    repeat (10) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("start_q_drained", start_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
